// File: rtl/dp_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dp_access_ctrl
//  Description : Sequences pointer-based memory accesses. SETPTR loads the
//                external dynamic pointer; LOAD/STORE access memory at the
//                pointer and then post-increment it; PEEK reads without the
//                increment. A wait counter aborts memory accesses that go
//                unacknowledged for too long.
//  Revision    : 1.0  initial release
// ============================================================================
module dp_access_ctrl #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,

    input  logic [15:0] dp_addr,
    output logic        load_dp,
    output logic        inc_dp,
    output logic [15:0] dp_data_in,

    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    // Command encodings
    localparam logic [1:0] OP_SETPTR = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_PEEK   = 2'b11;

    // Last wait-count value before an unacknowledged access gives up
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDP  = 3'd1,
        ST_MEM  = 3'd2,
        ST_INC  = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

    state_t     r_state;
    logic [1:0] r_op;
    logic [7:0] r_wait_cnt;

    // Control FSM with every output registered; strobes default low each cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_SETPTR;
            r_wait_cnt <= 8'd0;
            cmd_ready  <= 1'b0;
            load_dp    <= 1'b0;
            inc_dp     <= 1'b0;
            dp_data_in <= 16'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'd0;
            mem_wdata  <= 16'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 16'd0;
            rsp_err    <= 1'b0;
        end else begin
            load_dp <= 1'b0;
            inc_dp  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // cmd_ready is low for the first idle cycle after reset,
                    // so a command is only taken once it has been advertised.
                    if (cmd_valid && cmd_ready) begin
                        r_op      <= cmd_op;
                        cmd_ready <= 1'b0;
                        if (cmd_op == OP_SETPTR) begin
                            dp_data_in <= cmd_data;
                            load_dp    <= 1'b1;
                            r_state    <= ST_LDP;
                        end else begin
                            // Address, direction and data are frozen here and
                            // stay constant for the whole memory phase.
                            mem_req    <= 1'b1;
                            mem_we     <= (cmd_op == OP_STORE);
                            mem_addr   <= dp_addr;
                            mem_wdata  <= cmd_data;
                            r_wait_cnt <= 8'd0;
                            r_state    <= ST_MEM;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                ST_LDP: begin
                    // load_dp was high for exactly this one cycle
                    cmd_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end

                ST_MEM: begin
                    // An acknowledge takes priority over a coincident timeout
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        rsp_err <= 1'b0;
                        if (r_op == OP_STORE) begin
                            rsp_data <= mem_wdata;
                        end else begin
                            rsp_data <= mem_rdata;
                        end
                        if (r_op == OP_PEEK) begin
                            rsp_valid <= 1'b1;
                            r_state   <= ST_RSP;
                        end else begin
                            inc_dp  <= 1'b1;
                            r_state <= ST_INC;
                        end
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        // Abandon the access: error response, pointer untouched
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_data  <= 16'd0;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RSP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                ST_INC: begin
                    // inc_dp was high for this one cycle; present the response
                    rsp_valid <= 1'b1;
                    r_state   <= ST_RSP;
                end

                ST_RSP: begin
                    // Payload holds until the consumer takes it
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_access_ctrl
//  Description : Self-checking bench for dp_access_ctrl. Each directed command
//                is expanded into its expected cycle-by-cycle output timeline;
//                an external dynamic pointer is modelled to drive dp_addr.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dp_access_ctrl;

    localparam int TO = 4;

    localparam logic [1:0] OP_SET   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_PEEK  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_data = 16'd0;
    logic [15:0] dp_addr = 16'd0;
    logic        load_dp;
    logic        inc_dp;
    logic [15:0] dp_data_in;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;

    dp_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .dp_addr    (dp_addr),
        .load_dp    (load_dp),
        .inc_dp     (inc_dp),
        .dp_data_in (dp_data_in),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle
    typedef struct packed {
        logic        cmd_ready;
        logic        load_dp;
        logic        inc_dp;
        logic [15:0] dp_data_in;
        logic        mem_req;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        rsp_valid;
        logic [15:0] rsp_data;
        logic        rsp_err;
    } exp_t;

    exp_t        ex;
    logic        full = 1'b0;    // compare every field, not just the qualified ones
    logic        chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          tot_load = 0;
    int          tot_inc = 0;
    int          tot_req = 0;
    int          tot_rise = 0;
    int          rise_cyc = -1;
    logic [15:0] rise_data = 16'd0;
    logic        rise_err = 1'b0;
    logic        prev_rv = 1'b0;
    logic [15:0] ptr = 16'd0;    // model of the external dynamic pointer

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.cmd_ready = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle comparison of all meaningful outputs against the expectation
    task automatic compare_cycle();
        check("cmd_ready", 16'(cmd_ready), 16'(ex.cmd_ready));
        check("load_dp",   16'(load_dp),   16'(ex.load_dp));
        check("inc_dp",    16'(inc_dp),    16'(ex.inc_dp));
        check("mem_req",   16'(mem_req),   16'(ex.mem_req));
        check("rsp_valid", 16'(rsp_valid), 16'(ex.rsp_valid));
        if (full || ex.load_dp)
            check("dp_data_in", dp_data_in, ex.dp_data_in);
        if (full || ex.mem_req) begin
            check("mem_we",    16'(mem_we), 16'(ex.mem_we));
            check("mem_addr",  mem_addr,    ex.mem_addr);
            check("mem_wdata", mem_wdata,   ex.mem_wdata);
        end
        if (full || ex.rsp_valid) begin
            check("rsp_data", rsp_data,     ex.rsp_data);
            check("rsp_err",  16'(rsp_err), 16'(ex.rsp_err));
        end
        if (load_dp) tot_load++;
        if (inc_dp)  tot_inc++;
        if (mem_req) tot_req++;
        if (rsp_valid && !prev_rv) begin
            tot_rise++;
            rise_cyc  = cyc;
            rise_data = rsp_data;
            rise_err  = rsp_err;
        end
        prev_rv = rsp_valid;
    endtask

    // Finish the current cycle: compare mid-cycle, then move past the next edge
    task automatic step();
        @(negedge clk);
        if (chk_en) compare_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        ex = idle_exp();
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ack   = 1'b1;               // stray acks must be ignored
            mem_rdata = 16'($urandom);
            step();
        end
        mem_ack = 1'b0;
    endtask

    // One command. ack_at: MEM cycle carrying mem_ack (0 or beyond TO = none).
    // hold: cycles of rsp_ready=0 before the response is taken.
    // rst_at: MEM cycle in which reset is asserted (0 = never).
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] data, input int ack_at,
                          input logic [15:0] rdata, input int hold, input int rst_at,
                          output int acc);
        logic [15:0] a;
        bit          to;
        int          n;
        ex = idle_exp();
        full = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        dp_addr   = ptr;
        mem_ack   = 1'b0;
        a   = ptr;
        acc = cyc;
        step();
        // Scramble the command inputs to show they were latched
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 16'($urandom);
        if (op == OP_SET) begin
            ex = '0;
            ex.load_dp    = 1'b1;
            ex.dp_data_in = data;
            step();
            ptr     = data;
            dp_addr = ptr;
            return;
        end
        to = (ack_at < 1) || (ack_at > TO);
        n  = to ? TO : ack_at;
        for (int k = 1; k <= n; k++) begin
            ex = '0;
            ex.mem_req   = 1'b1;
            ex.mem_we    = (op == OP_STORE);
            ex.mem_addr  = a;
            ex.mem_wdata = data;
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rdata : 16'($urandom);
            if (k == rst_at) begin
                reset = 1'b0;
                step();
                reset   = 1'b1;
                mem_ack = 1'b0;
                ex   = '0;
                full = 1'b1;
                step();
                full = 1'b0;
                return;
            end
            step();
        end
        mem_ack = 1'b0;
        if (!to && op != OP_PEEK) begin
            ex = '0;
            ex.inc_dp = 1'b1;
            step();
            ptr     = ptr + 16'd1;
            dp_addr = ptr;
        end
        for (int k = 0; k <= hold; k++) begin
            ex = '0;
            ex.rsp_valid = 1'b1;
            ex.rsp_data  = to ? 16'd0 : ((op == OP_STORE) ? data : rdata);
            ex.rsp_err   = to;
            rsp_ready = (k == hold);
            mem_ack   = 1'b1;
            mem_rdata = 16'($urandom);
            step();
        end
        rsp_ready = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int b_load, b_inc, b_req, b_rise;

        // Reset: two cycles held low, then one cycle released with ready still low
        @(posedge clk);
        #1;
        cyc = 1;
        ex = '0;
        full = 1'b1;
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        full = 1'b0;

        // SETPTR 3800
        b_load = tot_load; b_rise = tot_rise;
        do_cmd(OP_SET, 16'h3800, 0, 16'h0, 0, 0, acc);
        idle(1);
        check("lit_setptr_load_pulses", 16'(tot_load - b_load), 16'd1);
        check("lit_setptr_no_rsp", 16'(tot_rise - b_rise), 16'd0);

        // LOAD at 3800, ack on second MEM cycle
        b_inc = tot_inc; b_req = tot_req;
        do_cmd(OP_LOAD, 16'h1111, 2, 16'hBEEF, 0, 0, acc);
        check("lit_load_data", rise_data, 16'hBEEF);
        check("lit_load_err", 16'(rise_err), 16'd0);
        check("lit_load_inc", 16'(tot_inc - b_inc), 16'd1);
        check("lit_load_req_cycles", 16'(tot_req - b_req), 16'd2);
        check("lit_load_latency", 16'(rise_cyc - acc), 16'd4);

        // STORE 5000 at 3801, immediate ack, one cycle of back-pressure
        b_inc = tot_inc;
        do_cmd(OP_STORE, 16'h5000, 1, 16'hDEAD, 1, 0, acc);
        check("lit_store_data", rise_data, 16'h5000);
        check("lit_store_inc", 16'(tot_inc - b_inc), 16'd1);
        check("lit_store_latency", 16'(rise_cyc - acc), 16'd3);

        // PEEK with no ack: timeout, response held 3 cycles
        b_inc = tot_inc; b_req = tot_req;
        do_cmd(OP_PEEK, 16'h0000, 0, 16'h0, 3, 0, acc);
        check("lit_to_req_cycles", 16'(tot_req - b_req), 16'd4);
        check("lit_to_err", 16'(rise_err), 16'd1);
        check("lit_to_data", rise_data, 16'd0);
        check("lit_to_inc", 16'(tot_inc - b_inc), 16'd0);

        // PEEK with immediate ack
        do_cmd(OP_PEEK, 16'h0000, 1, 16'h1234, 0, 0, acc);
        check("lit_peek_latency", 16'(rise_cyc - acc), 16'd2);
        check("lit_peek_data", rise_data, 16'h1234);

        // LOAD with ack on the timeout cycle
        do_cmd(OP_LOAD, 16'h0000, TO, 16'hCAFE, 0, 0, acc);
        check("lit_coincide_err", 16'(rise_err), 16'd0);
        check("lit_coincide_data", rise_data, 16'hCAFE);

        idle(3);

        // Reset in the middle of a LOAD, then a clean LOAD
        do_cmd(OP_LOAD, 16'h0000, 0, 16'h0, 0, 2, acc);
        do_cmd(OP_LOAD, 16'h0000, 1, 16'h0F0F, 0, 0, acc);
        check("lit_after_reset_data", rise_data, 16'h0F0F);

        // Pointer wrap and a STORE timeout
        do_cmd(OP_SET, 16'hFFFF, 0, 16'h0, 0, 0, acc);
        do_cmd(OP_LOAD, 16'h0000, 3, 16'hA5A5, 2, 0, acc);
        b_inc = tot_inc;
        do_cmd(OP_STORE, 16'h7777, TO + 1, 16'h0, 0, 0, acc);
        check("lit_store_to_err", 16'(rise_err), 16'd1);
        check("lit_store_to_inc", 16'(tot_inc - b_inc), 16'd0);
        do_cmd(OP_PEEK, 16'h0000, 2, 16'h4242, 0, 0, acc);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dp_access_ctrl.md
DP_ACCESS_CTRL -- requirements
Module: dp_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 8, the number of MEM-state cycles without mem_ack before the access aborts; legal range 1..255.
REQ-002 clk  in  1  the single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous reset, active-low; when sampled 0 on a rising edge, all state clears.
REQ-004 cmd_valid  in  1  a command is offered.
REQ-005 cmd_ready  out  1  the block accepts a command this cycle.
REQ-006 cmd_op  in  2  command code: 00 SETPTR, 01 LOAD (read, then post-increment), 10 STORE (write, then post-increment), 11 PEEK (read, no increment).
REQ-007 cmd_data  in  16  the new pointer value (SETPTR) or the write data (STORE).
REQ-008 dp_addr  in  16  the current pointer value, from the dynamic pointer's dp_data_out.
REQ-009 load_dp  out  1  one-cycle pulse that loads dp_data_in into the pointer.
REQ-010 inc_dp  out  1  one-cycle pulse that increments the pointer.
REQ-011 dp_data_in  out  16  the value to be loaded into the pointer.
REQ-012 mem_req / mem_we  out  1 / 1  the memory request, and its write qualifier.
REQ-013 mem_addr / mem_wdata  out  16 / 16  the memory address and write data.
REQ-014 mem_ack / mem_rdata  in  1 / 16  the memory completion strobe and read data.
REQ-015 rsp_valid / rsp_ready  out / in  1 / 1  the response handshake.
REQ-016 rsp_data / rsp_err  out  16 / 1  the response payload and the timeout flag.

Function
REQ-017 The block SHALL use five states: IDLE, LDP, MEM, INC, RSP; cmd_ready SHALL be 1 only in IDLE.
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_op, cmd_data and dp_addr SHALL be latched at that edge.
REQ-019 SETPTR SHALL move to LDP, where load_dp=1 and dp_data_in=latched cmd_data for exactly one cycle, then return to IDLE; no response is generated.
REQ-020 LOAD, STORE and PEEK SHALL move to MEM with the following outputs:
  - mem_req=1;
  - mem_addr=latched dp_addr;
  - mem_we=1 only for STORE;
  - mem_wdata=latched cmd_data.
  All of these SHALL be held stable until the access leaves MEM.
REQ-021 In MEM, mem_ack=1 SHALL complete the access at that edge:
  - mem_rdata is captured for LOAD and PEEK;
  - for STORE, the latched cmd_data becomes the response data;
  - mem_req SHALL be 0 in the next cycle.
REQ-022 After a completed LOAD or STORE the block SHALL enter INC for one cycle (inc_dp=1), then RSP; after PEEK it SHALL go directly to RSP.
REQ-023 An 8-bit wait counter SHALL clear on entry to MEM and increment on each MEM cycle without mem_ack. When it reaches TIMEOUT-1 with no ack, the access SHALL abort to RSP with these outputs:
  - rsp_err=1;
  - rsp_data=0;
  - no inc_dp pulse.
REQ-024 If mem_ack and timeout coincide in the same cycle, mem_ack SHALL win: the access completes normally with rsp_err=0.
REQ-025 In RSP, rsp_valid SHALL be 1, with rsp_data and rsp_err held stable until rsp_ready=1; the block SHALL return to IDLE on that edge.
REQ-026 mem_ack arriving outside MEM SHALL be ignored.
REQ-027 The pointer SHALL wrap through the dynamic pointer's own 16-bit increment; this block performs no address arithmetic.
REQ-028 write_dp is not driven by this block; the integrator SHALL tie it to 0.
REQ-029 Minimum latency, accept edge to rsp_valid:
  - LOAD/STORE with ack in the first MEM cycle: 3 cycles;
  - PEEK: 2 cycles.

Reset
REQ-030 On reset=0 the block SHALL enter IDLE at the next edge from any state (including MEM with mem_req=1), and clear all registered outputs:
  - load_dp, inc_dp, mem_req, mem_we, rsp_valid, rsp_err: 0;
  - dp_data_in, mem_addr, mem_wdata, rsp_data: 0;
  - wait counter: 0.
REQ-031 cmd_ready SHALL be 0 while reset=0 and 1 in the first cycle after reset is released.

Verification
REQ-032 SETPTR, cmd_data=16'h3800 -> exactly one load_dp pulse with dp_data_in=16'h3800; no rsp_valid.
REQ-033 LOAD with dp_addr=16'h3800, mem_ack on the second MEM cycle with mem_rdata=16'hBEEF -> mem_addr=16'h3800 and mem_we=0, then one inc_dp pulse, then rsp_data=16'hBEEF with rsp_err=0.
REQ-034 STORE, cmd_data=16'h5000, dp_addr=16'h3801, immediate ack -> mem_we=1, mem_wdata=16'h5000, one inc_dp pulse, rsp_data=16'h5000.
REQ-035 PEEK with TIMEOUT=4 and no ack -> mem_req high 4 cycles, then rsp_err=1, rsp_data=0, no inc_dp; also hold rsp_ready=0 for 3 cycles -> response stable and cmd_ready=0 throughout.
REQ-036 Ack coinciding with the timeout cycle -> rsp_err=0 and the captured data is returned.
REQ-037 reset=0 asserted during MEM -> mem_req=0 and IDLE at the next edge; a following LOAD completes normally.
